if_fetch_queue: RTL and testbench

- Instruction-fetch responder that sits between the program counter and decode.
- Takes the current PC value and issues one instruction-memory read per address using a req/gnt + rvalid protocol.
- Buffers returned {pc, instr} pairs in a small FIFO that drains to decode through a valid/ready handshake.
- Drives `pc_advance`, the PC hold/advance select (1 = PC loads next value, 0 = PC holds), and handles branch flushes.

---
 rtl/if_fetch_queue.sv | 176 +++++++++++++++++
 tb/tb_if_fetch_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// if_fetch_queue
// Instruction-fetch responder between the program counter and decode.
// Issues one memory read per PC value over a req/gnt + rvalid protocol and
// buffers the returned {pc, instr} pairs in a small FIFO. Decode drains the
// FIFO with a valid/ready handshake. A branch flush clears the FIFO and drops
// any fetch still in flight.
//
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   i_pc_addr        current PC; held constant by the PC while o_pc_advance=0
//   i_flush          branch taken this cycle; PC loads the target next edge
//   o_pc_advance     1 = PC may update at the next edge, 0 = PC holds
//   o_mem_req        memory read request, held until i_mem_gnt or a flush
//   o_mem_addr       request address
//   i_mem_gnt        memory accepted the request this cycle
//   i_mem_rvalid     read data valid (never in the gnt cycle)
//   i_mem_rdata      read data
//   o_id_valid       FIFO head valid
//   o_id_instr       head instruction
//   o_id_pc          head address
//   i_id_ready       decode consumes the head this cycle
//   o_count          FIFO occupancy
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 64,
  parameter int IW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [AW-1:0]            i_pc_addr,
  input  logic                     i_flush,
  output logic                     o_pc_advance,
  output logic                     o_mem_req,
  output logic [AW-1:0]            o_mem_addr,
  input  logic                     i_mem_gnt,
  input  logic                     i_mem_rvalid,
  input  logic [IW-1:0]            i_mem_rdata,
  output logic                     o_id_valid,
  output logic [IW-1:0]            o_id_instr,
  output logic [AW-1:0]            o_id_pc,
  input  logic                     i_id_ready,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_DATA,
    S_DISCARD
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_mem_req;
  logic            w_mem_req_next;
  logic [AW-1:0]   r_mem_addr;
  logic [AW-1:0]   w_mem_addr_next;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_fifo_pc    [DEPTH];
  logic [IW-1:0]   r_fifo_instr [DEPTH];
  logic            w_push;
  logic            w_pop;
  logic            w_space;

  // A pop in a flush cycle is ignored: the flush empties the FIFO anyway.
  assign w_pop = o_id_valid && i_id_ready && !i_flush;

  // Room for one more fetch after this cycle's pop. The single outstanding
  // fetch reserves its slot here, so a later push can never find the FIFO full.
  assign w_space = (r_count != CW'(DEPTH)) || w_pop;

  // ---------------- fetch FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_mem_req  <= w_mem_req_next;
      r_mem_addr <= w_mem_addr_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_mem_req_next  = r_mem_req;
    w_mem_addr_next = r_mem_addr;
    w_push          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!i_flush && w_space) begin
          w_mem_req_next  = 1'b1;
          w_mem_addr_next = i_pc_addr;
          w_state_next    = S_REQ;
        end
      end
      S_REQ: begin
        if (i_mem_gnt) begin
          // A grant coinciding with a flush still produces a response,
          // which must be swallowed.
          w_mem_req_next = 1'b0;
          w_state_next   = i_flush ? S_DISCARD : S_WAIT_DATA;
        end else if (i_flush) begin
          w_mem_req_next = 1'b0;
          w_state_next   = S_IDLE;
        end
      end
      S_WAIT_DATA: begin
        if (i_mem_rvalid) begin
          w_push       = !i_flush;
          w_state_next = S_IDLE;
        end else if (i_flush) begin
          w_state_next = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (i_mem_rvalid) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // PC moves once per granted fetch, or to the branch target on flush.
  assign o_pc_advance = ((r_state == S_REQ) && i_mem_gnt) || i_flush;
  assign o_mem_req    = r_mem_req;
  assign o_mem_addr   = r_mem_addr;

  // ---------------- FIFO control ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- FIFO storage ----------------
  // Entries reset to zero so the head outputs read 0 out of reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_fifo_pc[gi]    <= '0;
        r_fifo_instr[gi] <= '0;
      end else if (w_push && (r_wr_ptr == PW'(gi))) begin
        r_fifo_pc[gi]    <= r_mem_addr;
        r_fifo_instr[gi] <= i_mem_rdata;
      end
    end
  end

  assign o_id_valid = (r_count != '0);
  assign o_id_pc    = r_fifo_pc[r_rd_ptr];
  assign o_id_instr = r_fifo_instr[r_rd_ptr];
  assign o_count    = r_count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue. A PC model, a memory responder and a
// scoreboard queue of expected {pc, instr} entries drive and check the block.
module tb_if_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 64;
  localparam int IW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [AW-1:0]  pc_addr;
  logic           flush;
  logic           pc_advance;
  logic           mem_req;
  logic [AW-1:0]  mem_addr;
  logic           mem_gnt;
  logic           mem_rvalid;
  logic [IW-1:0]  mem_rdata;
  logic           id_valid;
  logic [IW-1:0]  id_instr;
  logic [AW-1:0]  id_pc;
  logic           id_ready;
  logic [CW-1:0]  count;

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_pc_addr    (pc_addr),
    .i_flush      (flush),
    .o_pc_advance (pc_advance),
    .o_mem_req    (mem_req),
    .o_mem_addr   (mem_addr),
    .i_mem_gnt    (mem_gnt),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata),
    .o_id_valid   (id_valid),
    .o_id_instr   (id_instr),
    .o_id_pc      (id_pc),
    .i_id_ready   (id_ready),
    .o_count      (count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } ent_t;

  ent_t          q[$];
  logic [AW-1:0] pc_m;
  int            epoch;
  bit            pend;
  int            lat;
  int            pend_epoch;
  logic [AW-1:0] pend_addr;
  int            n_popped;
  int            n_resp;

  bit            prev_req, prev_gnt, prev_flush, prev_pend, prev_space;
  logic [AW-1:0] prev_addr;

  int p_ready, p_gnt, p_flush, max_lat;

  // One cycle: entered and left at posedge+1.
  task automatic step();
    bit            exp_req, pop, grant, resp;
    logic [AW-1:0] target;
    int            e0;
    ent_t          ent;

    // Registered outputs against what last cycle's events imply.
    exp_req = prev_req ? (!prev_gnt && !prev_flush) : (!prev_pend && !prev_flush && prev_space);
    check_val("mem_req", mem_req, exp_req);
    if (mem_req && prev_req)  check_val("mem_addr_hold", mem_addr, prev_addr);
    if (mem_req && !prev_req) check_val("mem_addr_pc", mem_addr, pc_m);
    check_val("count", count, 64'(q.size()));
    check_val("id_valid", id_valid, q.size() != 0);
    if (q.size() != 0) begin
      check_val("id_pc", id_pc, q[0].pc);
      check_val("id_instr", id_instr, q[0].instr);
    end

    // Drive this cycle's inputs.
    flush      = ($urandom_range(99, 0) < p_flush);
    target     = {32'h0, $urandom} & ~64'h3;
    id_ready   = ($urandom_range(99, 0) < p_ready);
    mem_gnt    = mem_req && ($urandom_range(99, 0) < p_gnt);
    mem_rvalid = pend && (lat == 0);
    mem_rdata  = (n_resp == 0) ? 32'h0050_0093 : $urandom;
    #1;
    check_val("pc_advance", pc_advance, (mem_req && mem_gnt) || flush);

    pop        = (q.size() != 0) && id_ready && !flush;
    prev_space = (q.size() - (pop ? 1 : 0)) < DEPTH;
    prev_req   = mem_req;
    prev_gnt   = mem_gnt;
    prev_flush = flush;
    prev_addr  = mem_addr;
    prev_pend  = pend;
    grant      = mem_req && mem_gnt;
    resp       = mem_rvalid;
    e0         = epoch;

    @(posedge clk);
    if (flush) begin
      q.delete();
      epoch++;
    end else begin
      if (pop) begin
        ent = q.pop_front();
        n_popped++;
        $display("pop  pc=0x%0h instr=0x%08h count_after=%0d", ent.pc, ent.instr, q.size());
      end
      if (resp && pend_epoch == e0) q.push_back('{pc: pend_addr, instr: mem_rdata});
    end
    if (resp) begin
      pend = 0;
      n_resp++;
    end else if (pend) begin
      lat--;
    end
    if (grant) begin
      pend       = 1;
      lat        = $urandom_range(max_lat, 0);
      pend_addr  = mem_addr;
      pend_epoch = e0;
    end
    if (flush) pc_m = target;
    else if (grant) pc_m = pc_m + 64'd4;
    pc_addr = pc_m;
    #1;
  endtask

  task automatic quiet_inputs();
    flush      = 1'b0;
    id_ready   = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  // Release reset between edges; the next edge finds the block idle with room.
  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    prev_req   = 0;
    prev_gnt   = 0;
    prev_flush = 0;
    prev_pend  = 0;
    prev_space = 1;
  endtask

  initial begin
    bit found;
    rst_n    = 1'b0;
    pc_m     = '0;
    pc_addr  = '0;
    epoch    = 0;
    pend     = 0;
    lat      = 0;
    n_popped = 0;
    n_resp   = 0;
    quiet_inputs();
    #12;
    check_val("rst_mem_req", mem_req, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_count", count, 0);
    check_val("rst_id_valid", id_valid, 0);
    check_val("rst_pc_advance", pc_advance, 0);
    check_val("rst_id_pc", id_pc, 0);
    check_val("rst_id_instr", id_instr, 0);
    release_reset();

    // Fill: decode stalled, immediate memory, no branches.
    p_ready = 0; p_gnt = 100; p_flush = 0; max_lat = 0;
    for (int i = 0; i < 20; i++) step();
    check_val("fill_count", count, DEPTH);
    check_val("fill_req_idle", mem_req, 0);
    check_val("fill_head_pc", id_pc, 0);
    check_val("fill_head_instr", id_instr, 32'h0050_0093);
    check_val("fill_pc_hold", pc_advance, 0);

    // Drain and resume, then randomized traffic with varied knobs.
    p_ready = 100;
    for (int i = 0; i < 12; i++) step();
    for (int k = 0; k < 6; k++) begin
      p_ready = $urandom_range(100, 20);
      p_gnt   = $urandom_range(100, 30);
      p_flush = $urandom_range(12, 0);
      max_lat = $urandom_range(3, 0);
      for (int i = 0; i < 250; i++) step();
    end

    // Reset while a request is pending.
    p_flush = 0; p_gnt = 0; p_ready = 30;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (mem_req) found = 1;
      else step();
    end
    check_val("rst_mid_found_req", mem_req, 1);
    rst_n = 1'b0;
    quiet_inputs();
    #1;
    check_val("rst_mid_mem_req", mem_req, 0);
    check_val("rst_mid_count", count, 0);
    check_val("rst_mid_id_valid", id_valid, 0);
    check_val("rst_mid_id_pc", id_pc, 0);
    q.delete();
    pend = 0;
    epoch++;
    release_reset();

    p_ready = 70; p_gnt = 80; p_flush = 4; max_lat = 2;
    for (int i = 0; i < 300; i++) step();
    check_val("progress", n_popped >= 100, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
